inv_sub_bytes_seq: RTL
======================

// Module: inv_sub_bytes_seq
// PURPOSE
//  Iterative InvSubBytes stage of the AES-256 decryption datapath. It sits directly downstream of
//  the inverse-shift-rows stage and consumes its 128-bit state. It replaces every state byte with
//  InvSbox(byte), BYTES_PER_CYCLE bytes per clock. The S-box is computed arithmetically, with no table.
//  A valid/ready handshake on both sides lets the round controller throttle the stage.
// PARAMETERS
//  BYTES_PER_CYCLE  4  bytes substituted per RUN cycle. Legal: 1,2,4,8,16. Any other value is an elaboration error.
// PORTS
//  clk        input   1    rising-edge clock, single domain
//  rst_n      input   1    asynchronous reset, active-low
//  in_valid   input   1    in_data is valid
//  in_ready   output  1    stage can accept a state (high only in IDLE)
//  in_data    input   128  state after inverse shift rows; byte k = [127-8k -: 8], k=0..15
//  out_valid  output  1    out_data holds the fully substituted state
//  out_ready  input   1    consumer accepts out_data
//  out_data   output  128  substituted state, same byte ordering as in_data
//  busy       output  1    high in RUN or DONE
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, cnt=0, data register=0. Outputs: in_ready=1 (after release),
//    out_valid=0, out_data=0, busy=0. Reset mid-RUN or mid-DONE discards the block with no output.
//  - N = 16/BYTES_PER_CYCLE. cnt is a log2(N)-bit counter; for N=1 the counter is unused.
//  - IDLE: in_ready=1. At an edge with in_valid=1, load in_data into the data register, set cnt=0,
//    and go to RUN. With in_valid=0, stay in IDLE.
//  - RUN: each edge replaces bytes k = cnt*BYTES_PER_CYCLE .. +BYTES_PER_CYCLE-1 (MSB byte first),
//    then increments cnt. At the edge where cnt==N-1, go to DONE. No wrap-around into another pass.
//  - DONE: out_valid=1 and out_data=register, both held stable until out_ready=1.
//    At an edge with out_ready=1, go to IDLE. out_ready is ignored outside DONE.
//  - Latency: out_valid rises exactly N cycles after the accept edge (N=4 at the default).
//    Minimum spacing between accept edges is N+2 cycles. No overlap: in_ready=0 in RUN and DONE,
//    so in_valid is ignored there. A state accepted in IDLE while out_ready is also high behaves normally.
//  - InvSbox(x) = GFinv(InvAffine(x)).
//    InvAffine bit i: b_i = x[(i+2)%8] ^ x[(i+5)%8] ^ x[(i+7)%8] ^ c_i, with c = 8'h05.
//    GFinv: multiplicative inverse in GF(2^8) mod x^8+x^4+x^3+x+1 (9'h11B), computed as y^254
//    via a square-and-multiply chain; GFinv(0) = 0.
//    BYTES_PER_CYCLE parallel instances sit in a generate loop.
//  - All state updates are registered. The S-box path is combinational between the register and the next-state mux.
// TESTING
//  1. Reset: rst_n=0 then released -> out_valid=0, out_data=0, in_ready=1, busy=0.
//  2. in_data=128'h637C777BF26B6FC53001672BFED7AB76, single pulse -> after 4 cycles out_valid=1,
//     out_data=128'h000102030405060708090A0B0C0D0E0F.
//  3. Corner bytes: in_data={16{8'h00}} -> {16{8'h52}}; {16{8'h16}} -> {16{8'hFF}};
//     {16{8'hED}} -> {16{8'h53}}.
//  4. Back-pressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_data held stable.
//     Meanwhile in_valid=1 with a second state -> not accepted. Raise out_ready -> next cycle IDLE,
//     second state accepted.
//  5. Reset mid-RUN: rst_n pulsed low after 2 RUN cycles -> immediate IDLE, out_valid never asserted,
//     next block processed correctly.
//  6. Sweep BYTES_PER_CYCLE in {1,2,4,8,16} with the scenario-2 vector -> out_valid after 16/8/4/2/1
//     cycles, identical out_data. 1000 random states checked against a software InvSbox model.

Source files
------------

// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes stage: substitutes BYTES_PER_CYCLE state bytes per clock
// using an arithmetic inverse S-box, with valid/ready handshakes on both sides.
module inv_sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int N       = 16 / BYTES_PER_CYCLE;
    localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;
    localparam int CHUNK_W = 8 * BYTES_PER_CYCLE;

    generate
        if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
              BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
            $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [127:0]         data_reg, data_next;
    logic [127:0]         run_data;
    logic [CHUNK_W-1:0]   chunk_in, chunk_sub;
    logic [6:0]           sel_shift;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // y^254 = y^2 * y^4 * ... * y^128; a zero input yields zero naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        logic [7:0] b;
        logic [7:0] c;
        c = 8'h05;
        for (int i = 0; i < 8; i++) begin
            b[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8] ^ c[i];
        end
        return b;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(inv_affine(x));
    endfunction

    // Chunk 0 is the most significant CHUNK_W bits of the state.
    assign sel_shift = 7'((N - 1 - int'(cnt_reg)) * CHUNK_W);
    assign chunk_in  = CHUNK_W'(data_reg >> sel_shift);

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_sbox
            assign chunk_sub[CHUNK_W-1-8*gi -: 8] = inv_sbox(chunk_in[CHUNK_W-1-8*gi -: 8]);
        end
        for (gi = 0; gi < N; gi++) begin : g_merge
            assign run_data[127-gi*CHUNK_W -: CHUNK_W] =
                (cnt_reg == CNT_W'(gi)) ? chunk_sub : data_reg[127-gi*CHUNK_W -: CHUNK_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    data_next  = in_data;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                data_next = run_data;
                if (cnt_reg == CNT_W'(N - 1)) begin
                    cnt_next   = '0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign out_data  = data_reg;

endmodule
